row_remap_table: RTL and testbench
==================================

Name: row_remap_table

Overview:
- Programmable row-address remapping lookup table: a DEPTH x DATA_W distributed RAM indexed by the incoming readout row address.
- Sits between the row-sequencer and the ADC readout path. Maps the logical row (rowadd_in) to a physical row (rowadd_out).
- The host rewrites entries at runtime through a single-cycle write port.
- After reset the table self-initialises to the identity mapping.

Parameters:
- ADDR_W, 9, width of rowadd_in and mem_write_addr.
- DATA_W, 9, width of rowadd_out and mem_write_data.
- DEPTH, 2**ADDR_W, number of table entries.
- MAX_ROW, 511, highest legal mapped row value; used only by the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rowadd_in  in  ADDR_W  logical row address to translate.
- rowadd_out  out  DATA_W  mapped row address, registered.
- mem_write_addr  in  ADDR_W  table entry to write.
- mem_write_data  in  DATA_W  value to store.
- we  in  1  write strobe; one write per cycle it is high.
- init_done  out  1  high once the identity initialisation sweep has completed.
- range_err  out  1  sticky out-of-range write flag; present only with ROW_MAP_RANGE_CHECK_EN, otherwise tied 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rowadd_out = 0, init_done = 0, range_err = 0.
  - Init pointer = 0; FSM enters S_INIT.
  - RAM contents are not cleared by reset itself.
- FSM state S_INIT:
  - Each clock writes RAM[ptr] = ptr (zero-extended/truncated to DATA_W); ptr increments.
  - After writing DEPTH-1, go to S_RUN and set init_done = 1 on that same edge.
  - Duration: exactly DEPTH cycles after reset release.
- During S_INIT:
  - rowadd_out <= rowadd_in (registered identity bypass, 1-cycle latency).
  - Host writes are dropped.
- FSM state S_RUN:
  - rowadd_out <= RAM[rowadd_in] every cycle; latency 1 clock.
  - If we = 1, RAM[mem_write_addr] <= mem_write_data at the same edge.
- Same-cycle read/write collision (S_RUN, we = 1, mem_write_addr == rowadd_in): write-first. rowadd_out takes mem_write_data on that edge.
- Writes to one address on consecutive cycles: last write wins.
- we held high for N cycles performs N writes, using the address/data present on each edge.
- Addresses are full-range (0..DEPTH-1); no wrap logic inside the block.
- Reset asserted mid-sweep or mid-run:
  - Immediately returns to reset values.
  - The sweep restarts from address 0 after release.
- S_RUN is held until the next reset; no other path back to S_INIT.

Optional Feature:
- Macro: ROW_MAP_RANGE_CHECK_EN.
- Defined:
  - In S_RUN, a write with mem_write_data > MAX_ROW is discarded (RAM unchanged).
  - range_err sets to 1 on the next edge and stays high until reset.
  - Legal writes behave normally.
- Undefined:
  - All writes are accepted.
  - range_err is constant 0.
  - No comparator is synthesised.

Test Plan:
- Reset, then check bypass: hold rst_n low 3 cycles, release, drive rowadd_in = 37 → rowadd_out = 37 one cycle later; init_done rises exactly 512 cycles after release.
- Identity after init: after init_done, sweep rowadd_in 0..240 → rowadd_out equals rowadd_in, each with 1-cycle latency.
- Write then read: write addr 5 = 6, addr 240 = 0; then read rowadd_in = 5 → 6, rowadd_in = 240 → 0, rowadd_in = 6 → 6 (untouched).
- Collision: rowadd_in = 10 and we with addr 10 / data 99 on the same edge → rowadd_out = 99 on that edge. A write during S_INIT (addr 3 / data 7) is ignored → 3 reads back as 3.
- Reset mid-run: after remapping entry 5 = 6, pulse rst_n low asynchronously between edges → rowadd_out = 0 immediately, init_done = 0; after the resweep, entry 5 reads 5.
- Range check (macro defined, MAX_ROW = 240): write addr 4 = 300 → entry 4 stays 4, range_err = 1 and remains set. A subsequent legal write addr 4 = 200 reads back 200.

Source files
------------

// File: rtl/row_remap_table.sv
// Row-address remapping LUT: logical row -> physical row, identity-initialised after reset.
// Optional sticky range check on host writes enabled by defining ROW_MAP_RANGE_CHECK_EN.
module row_remap_table #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned DEPTH   = 2**ADDR_W,
  parameter int unsigned MAX_ROW = 511
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rowadd_in,
  output logic [DATA_W-1:0] rowadd_out,
  input  logic [ADDR_W-1:0] mem_write_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              we,
  output logic              init_done,
  output logic              range_err
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              wr_legal;
  logic              host_wr;
  logic [DATA_W-1:0] mem [DEPTH];

  if (MAX_ROW >= (2**DATA_W)) begin : g_max_row_check
    $error("row_remap_table: MAX_ROW not representable in DATA_W bits");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      init_done <= (state_nxt == S_RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      S_INIT: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN: state_nxt = S_RUN;
    endcase
  end

`ifdef ROW_MAP_RANGE_CHECK_EN
  assign wr_legal = (32'(mem_write_data) <= MAX_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  range_err <= 1'b0;
    else if (state == S_RUN && we && !wr_legal)  range_err <= 1'b1;
  end
`else
  assign wr_legal  = 1'b1;
  assign range_err = 1'b0;
`endif

  assign host_wr = we && (state == S_RUN) && wr_legal;

  // RAM has no reset; the init sweep owns the write port until S_RUN.
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[ptr] <= DATA_W'(ptr);
    else if (host_wr)
      mem[mem_write_addr] <= mem_write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rowadd_out <= '0;
    else if (state == S_INIT)
      rowadd_out <= DATA_W'(rowadd_in);
    else if (host_wr && (mem_write_addr == rowadd_in))
      rowadd_out <= mem_write_data;
    else
      rowadd_out <= mem[rowadd_in];
  end

endmodule

// File: tb/tb_row_remap_table.sv
// Self-checking bench for row_remap_table: directed steps plus random traffic against a table model.
module tb_row_remap_table;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 512;
`ifdef ROW_MAP_RANGE_CHECK_EN
  localparam int MAX_ROW = 240;
  localparam bit CHK     = 1'b1;
`else
  localparam int MAX_ROW = 511;
  localparam bit CHK     = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rowadd_in;
  logic [DATA_W-1:0] rowadd_out;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              we;
  logic              init_done;
  logic              range_err;

  row_remap_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MAX_ROW(MAX_ROW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rowadd_in     (rowadd_in),
    .rowadd_out    (rowadd_out),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .we            (we),
    .init_done     (init_done),
    .range_err     (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: table contents, cycles since reset release, sticky error flag.
  int tbl [DEPTH];
  int cnt;
  bit m_err;
  int m_out;

  int n_assert;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int in, input bit w, input int a, input int d);
    rowadd_in      = ADDR_W'(in);
    we             = w;
    mem_write_addr = ADDR_W'(a);
    mem_write_data = DATA_W'(d);
    @(posedge clk);
    if (cnt < DEPTH) begin
      m_out    = in;
      tbl[cnt] = cnt;
      cnt++;
    end else begin
      if (w) begin
        if (CHK && d > MAX_ROW) m_err = 1'b1;
        else                    tbl[a] = d;
      end
      m_out = tbl[in];
    end
    #1;
    check("rowadd_out", rowadd_out, m_out);
    check("init_done", init_done, cnt >= DEPTH);
    check("range_err", range_err, m_err);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rowadd_out", rowadd_out, 0);
    check("rst_init_done", init_done, 0);
    check("rst_range_err", range_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt   = 0;
    m_err = 1'b0;
  endtask

  task automatic rand_cycle();
    int in, a;
    in = $urandom_range(0, DEPTH - 1);
    a  = ($urandom_range(0, 3) == 0) ? in : $urandom_range(0, DEPTH - 1);
    cycle(in, $urandom_range(0, 1) == 1, a, $urandom_range(0, 511));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cnt      = 0;
    m_err    = 1'b0;
    rst_n    = 1'b1;
    rowadd_in      = '0;
    we             = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;

    do_reset();

    // Bypass during init; the host write here must be dropped.
    cycle(37, 1'b1, 3, 7);
    for (int i = 1; i < DEPTH; i++) rand_cycle();

    // Identity mapping after init
    for (int i = 0; i <= 240; i++) cycle(i, 1'b0, 0, 0);

    cycle(0, 1'b1, 5, 6);
    cycle(0, 1'b1, 240, 0);
    cycle(5, 1'b0, 0, 0);
    cycle(240, 1'b0, 0, 0);
    cycle(6, 1'b0, 0, 0);

    // Write-first collision, then the init-time write target
    cycle(10, 1'b1, 10, 99);
    cycle(3, 1'b0, 0, 0);

    // Back-to-back writes to one address: last wins
    cycle(0, 1'b1, 77, 11);
    cycle(0, 1'b1, 77, 12);
    cycle(77, 1'b0, 0, 0);

    for (int i = 0; i < 400; i++) rand_cycle();

    // Reset mid-run restores identity after the resweep
    cycle(0, 1'b1, 5, 6);
    cycle(5, 1'b0, 0, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) rand_cycle();
    cycle(5, 1'b0, 0, 0);

    // Out-of-range write (dropped only with range check enabled), then legal write
    cycle(0, 1'b1, 4, 300);
    cycle(4, 1'b0, 0, 0);
    cycle(0, 1'b1, 4, 200);
    cycle(4, 1'b0, 0, 0);
    for (int i = 0; i < 100; i++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
